freq_sweep_ctrl: RTL and testbench

- Sequencing controller that drives the 8-bit frequency code (freq_param) of the variable clock generator.
- Accepts commands over a valid/ready handshake in one of two modes:
  - ramp: glide one LSB at a time to a target code, then stop;
  - sweep: continuous triangle sweep between two codes.
- Each code is held for a programmable dwell, so the generated clock never jumps abruptly.
- Sits between the control/register logic and the clock generator, in the 1 MHz clk_in domain.

---
 rtl/freq_sweep_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sweep_ctrl.sv
// Purpose : sequences the 8-bit frequency code of the variable clock generator,
//           either gliding to a target code (ramp) or running a triangle sweep.
// Latency : an accepted command takes effect on the accept edge; each code is
//           held for DWELL_CYCLES cycles before the next +/-1 step.
// Backpres: cmd_ready is high only in IDLE, SWEEP_UP and SWEEP_DOWN with abort low.
//           A command is taken on the edge where cmd_valid && cmd_ready.
//
// Ports:
//   clk_in      single clock, all logic on posedge
//   reset       asynchronous, active-high
//   cmd_valid   command request
//   cmd_ready   combinational accept qualifier
//   cmd_mode    0 = ramp to cmd_hi, 1 = sweep cmd_lo..cmd_hi
//   cmd_lo      sweep lower bound (not used by ramp)
//   cmd_hi      ramp target or sweep upper bound
//   abort       stop and hold the present code
//   freq_param  registered code to the clock generator
//   busy        registered, high whenever not IDLE
//   done        registered one-cycle pulse when a ramp completes
module freq_sweep_ctrl #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned DWELL_W      = 16,
  parameter logic [7:0]  RESET_CODE   = 8'd0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_mode,
  input  logic [7:0] cmd_lo,
  input  logic [7:0] cmd_hi,
  input  logic       abort,
  output logic [7:0] freq_param,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SEEK       = 2'd1,
    S_SWEEP_UP   = 2'd2,
    S_SWEEP_DOWN = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_freq;
  logic [7:0]         w_freq_nxt;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_nxt;
  logic [7:0]         r_lo;
  logic [7:0]         r_hi;
  logic [7:0]         r_target;
  logic               r_sweep;   // SEEK is heading to the sweep start, not a ramp end
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  logic               w_accept;
  logic               w_cmd_sweep;
  logic [7:0]         w_cmd_target;
  logic               w_dwell_end;
  logic [7:0]         w_freq_inc;
  logic [7:0]         w_freq_dec;

  // A sweep with lo >= hi degenerates into a ramp to lo, so the target is
  // cmd_lo for every sweep command and cmd_hi for every ramp command.
  assign w_cmd_sweep  = cmd_mode & (cmd_lo < cmd_hi);
  assign w_cmd_target = cmd_mode ? cmd_lo : cmd_hi;
  assign w_accept     = cmd_valid & cmd_ready;
  assign w_dwell_end  = (r_dwell == DWELL_LAST);
  assign w_freq_inc   = r_freq + 8'd1;
  assign w_freq_dec   = r_freq - 8'd1;

  assign freq_param = r_freq;
  assign busy       = r_busy;
  assign done       = r_done;

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and step logic. Abort has priority; an accept (possible only
  // from IDLE or a sweep state) restarts from the current code.
  always_comb begin
    w_state_nxt = r_state;
    w_freq_nxt  = r_freq;
    w_dwell_nxt = r_dwell;
    w_done_nxt  = 1'b0;
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_dwell_nxt = '0;
    end else if (w_accept) begin
      w_dwell_nxt = '0;
      if (w_cmd_target == r_freq) begin
        if (w_cmd_sweep) begin
          w_state_nxt = S_SWEEP_UP;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end else begin
        w_state_nxt = S_SEEK;
      end
    end else if (r_state != S_IDLE) begin
      if (!w_dwell_end) begin
        w_dwell_nxt = r_dwell + DWELL_ONE;
      end else begin
        w_dwell_nxt = '0;
        case (r_state)
          S_SEEK: begin
            w_freq_nxt = (r_target > r_freq) ? w_freq_inc : w_freq_dec;
            if (w_freq_nxt == r_target) begin
              if (r_sweep) begin
                w_state_nxt = S_SWEEP_UP;
              end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
            end
          end
          S_SWEEP_UP: begin
            w_freq_nxt = w_freq_inc;
            if (w_freq_inc == r_hi) begin
              w_state_nxt = S_SWEEP_DOWN;
            end
          end
          S_SWEEP_DOWN: begin
            w_freq_nxt = w_freq_dec;
            if (w_freq_dec == r_lo) begin
              w_state_nxt = S_SWEEP_UP;
            end
          end
          default: begin
            w_freq_nxt = r_freq;
          end
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    cmd_ready  = ~abort & (r_state != S_SEEK);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_freq   <= RESET_CODE;
      r_dwell  <= '0;
      r_lo     <= 8'd0;
      r_hi     <= 8'd0;
      r_target <= 8'd0;
      r_sweep  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_freq  <= w_freq_nxt;
      r_dwell <= w_dwell_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_lo     <= cmd_lo;
        r_hi     <= cmd_hi;
        r_target <= w_cmd_target;
        r_sweep  <= w_cmd_sweep;
      end
    end
  end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: lane 0 uses a 4-cycle dwell, lane 1 a 1-cycle dwell.
// Expected output changes (freq/busy/done) are queued when a command is issued;
// a negedge monitor pops one entry for every observed change and compares it.
module tb_freq_sweep_ctrl;

  typedef struct {
    int lane;
    int cyc;
    int f;
    bit b;
    bit d;
  } ev_t;

  localparam int BIG = 1 << 30;

  logic       clk;
  logic       reset;
  logic       cv [2];
  logic       cm [2];
  logic       ab [2];
  logic       rdy[2];
  logic       bo [2];
  logic       dn [2];
  logic [7:0] clo[2];
  logic [7:0] chi[2];
  logic [7:0] fo [2];

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  int  m_freq[2];
  bit  m_busy[2];

  freq_sweep_ctrl #(.DWELL_CYCLES(4), .DWELL_W(16), .RESET_CODE(8'd0)) dut4 (
    .clk_in(clk), .reset(reset), .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_mode(cm[0]), .cmd_lo(clo[0]), .cmd_hi(chi[0]), .abort(ab[0]),
    .freq_param(fo[0]), .busy(bo[0]), .done(dn[0])
  );

  freq_sweep_ctrl #(.DWELL_CYCLES(1), .DWELL_W(4), .RESET_CODE(8'd0)) dut1 (
    .clk_in(clk), .reset(reset), .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_mode(cm[1]), .cmd_lo(clo[1]), .cmd_hi(chi[1]), .abort(ab[1]),
    .freq_param(fo[1]), .busy(bo[1]), .done(dn[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void push(input int l, input int c, input int f, input bit b, input bit d);
    ev_t e;
    e.lane = l; e.cyc = c; e.f = f; e.b = b; e.d = d;
    exp_q.push_back(e);
  endfunction

  // Ramp: one step per dwell toward 'to'; done with busy low on the last step.
  function automatic void push_ramp(input int l, input int a, input int from, input int to,
                                    input int d, input int lim);
    int n, s, lastf;
    n = (to > from) ? to - from : from - to;
    s = (to > from) ? 1 : -1;
    if (n == 0) begin
      push(l, a, from, 1'b0, 1'b1);
      push(l, a + 1, from, 1'b0, 1'b0);
      m_freq[l] = from;
      m_busy[l] = 1'b0;
      return;
    end
    if (!m_busy[l]) push(l, a, from, 1'b1, 1'b0);
    lastf = from;
    for (int k = 1; k <= n; k++) begin
      if (a + d * k > lim) break;
      lastf = from + s * k;
      if (k < n) begin
        push(l, a + d * k, lastf, 1'b1, 1'b0);
      end else begin
        push(l, a + d * k, lastf, 1'b0, 1'b1);
        if (a + d * k + 1 <= lim) push(l, a + d * k + 1, lastf, 1'b0, 1'b0);
      end
    end
    m_freq[l] = lastf;
    m_busy[l] = (lastf != to);
  endfunction

  // Sweep: seek to lo, then triangle lo..hi, events up to cycle 'lim'.
  function automatic void push_sweep(input int l, input int a, input int from, input int lo,
                                     input int hi, input int d, input int lim);
    int f, k, lastf;
    bit up;
    if (lo >= hi) begin
      push_ramp(l, a, from, lo, d, lim);
      return;
    end
    if (!m_busy[l]) push(l, a, from, 1'b1, 1'b0);
    f = from; k = 0; lastf = from;
    while (f != lo) begin
      k++;
      f = f + ((lo > f) ? 1 : -1);
      if (a + d * k <= lim) begin
        push(l, a + d * k, f, 1'b1, 1'b0);
        lastf = f;
      end
    end
    up = 1'b1;
    while (a + d * (k + 1) <= lim) begin
      k++;
      f = f + (up ? 1 : -1);
      push(l, a + d * k, f, 1'b1, 1'b0);
      lastf = f;
      if (f == hi) up = 1'b0;
      else if (f == lo) up = 1'b1;
    end
    m_freq[l] = lastf;
    m_busy[l] = 1'b1;
  endfunction

  task automatic issue(input int l, input bit mode, input int lo, input int hi, output int a);
    cv[l]  = 1'b1;
    cm[l]  = mode;
    clo[l] = 8'(lo);
    chi[l] = 8'(hi);
    #1;
    chk("accept_ready", int'(rdy[l]), 1);
    @(posedge clk);
    #1;
    a = cyc;
    cv[l] = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_events", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every change of (freq, busy, done) must match the queue head.
  initial begin : monitor
    logic [7:0] pf[2];
    logic       pb[2];
    logic       pd[2];
    ev_t        e;
    for (int l = 0; l < 2; l++) begin
      pf[l] = 8'd0; pb[l] = 1'b0; pd[l] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (!reset && (fo[l] !== pf[l] || bo[l] !== pb[l] || dn[l] !== pd[l])) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event lane%0d: actual cyc=%0d freq=%0d busy=%0d done=%0d, required no change",
                     l, cyc, fo[l], bo[l], dn[l]);
          end else begin
            e = exp_q.pop_front();
            if (e.lane != l || e.cyc != cyc || e.f != int'(fo[l]) || e.b != bo[l] || e.d != dn[l]) begin
              n_fail++;
              $display("FAIL event: actual lane%0d cyc=%0d freq=%0d busy=%0d done=%0d, required lane%0d cyc=%0d freq=%0d busy=%0d done=%0d",
                       l, cyc, fo[l], bo[l], dn[l], e.lane, e.cyc, e.f, e.b, e.d);
            end
          end
        end
        pf[l] = fo[l]; pb[l] = bo[l]; pd[l] = dn[l];
      end
    end
  end

  initial begin : stim
    int a, b;
    reset = 1'b1;
    for (int l = 0; l < 2; l++) begin
      cv[l] = 1'b0; cm[l] = 1'b0; ab[l] = 1'b0; clo[l] = 8'd0; chi[l] = 8'd0;
      m_freq[l] = 0; m_busy[l] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("reset_freq", int'(fo[0]), 0);
    chk("reset_busy", int'(bo[0]), 0);
    chk("reset_done", int'(dn[0]), 0);
    chk("reset_ready", int'(rdy[0]), 1);
    chk("reset_freq_d1", int'(fo[1]), 0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Ramp 0 -> 5: steps at +4..+20, done at +20
    issue(0, 1'b0, 0, 5, a);
    push_ramp(0, a, m_freq[0], 5, 4, BIG);
    drain(100);
    chk("ramp5_freq", int'(fo[0]), 5);
    chk("ramp5_ready", int'(rdy[0]), 1);

    // Ramp 5 -> 2, then ramp to 2 again (immediate done)
    issue(0, 1'b0, 0, 2, a);
    push_ramp(0, a, m_freq[0], 2, 4, BIG);
    drain(100);
    chk("ramp2_freq", int'(fo[0]), 2);
    issue(0, 1'b0, 0, 2, a);
    push_ramp(0, a, m_freq[0], 2, 4, BIG);
    drain(20);
    issue(0, 1'b0, 0, 5, a);
    push_ramp(0, a, m_freq[0], 5, 4, BIG);
    drain(100);

    // Sweep 3..6 from 5 through a full period, then abort with a command at code 5
    issue(0, 1'b1, 3, 6, a);
    push_sweep(0, a, m_freq[0], 3, 6, 4, a + 41);
    wait_cyc(a + 41);
    ab[0] = 1'b1; cv[0] = 1'b1; cm[0] = 1'b0; chi[0] = 8'h10;
    #1;
    chk("abort_ready_low", int'(rdy[0]), 0);
    push(0, a + 42, 5, 1'b0, 1'b0);
    m_busy[0] = 1'b0;
    @(posedge clk);
    #1;
    ab[0] = 1'b0; cv[0] = 1'b0;
    drain(20);
    chk("abort_freq", int'(fo[0]), 5);
    chk("abort_busy", int'(bo[0]), 0);

    // Sweep 5..7 starting at lo, preempted at code 6 by a ramp to 0x10
    issue(0, 1'b1, 5, 7, a);
    push_sweep(0, a, m_freq[0], 5, 7, 4, a + 13);
    wait_cyc(a + 13);
    issue(0, 1'b0, 0, 16, b);
    chk("preempt_accept_cycle", b - a, 14);
    push_ramp(0, b, m_freq[0], 16, 4, BIG);
    drain(100);
    chk("preempt_freq", int'(fo[0]), 16);

    // Sweep with lo >= hi behaves as ramp to lo (with done)
    issue(0, 1'b1, 6, 3, a);
    push_sweep(0, a, m_freq[0], 6, 3, 4, BIG);
    drain(100);
    chk("degen_sweep_freq", int'(fo[0]), 6);

    // Asynchronous reset mid-ramp, between clock edges
    issue(0, 1'b0, 0, 32, a);
    push_ramp(0, a, m_freq[0], 32, 4, a + 9);
    wait_cyc(a + 9);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_freq", int'(fo[0]), 0);
    chk("async_reset_busy", int'(bo[0]), 0);
    chk("async_reset_done", int'(dn[0]), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    m_freq[0] = 0; m_busy[0] = 1'b0;
    issue(0, 1'b0, 0, 5, a);
    push_ramp(0, a, m_freq[0], 5, 4, BIG);
    drain(100);
    chk("post_reset_ramp_freq", int'(fo[0]), 5);

    // One-cycle dwell: full-range ramps with no wrap
    issue(1, 1'b0, 0, 255, a);
    push_ramp(1, a, m_freq[1], 255, 1, BIG);
    drain(400);
    chk("d1_up_freq", int'(fo[1]), 255);
    issue(1, 1'b0, 0, 0, a);
    push_ramp(1, a, m_freq[1], 0, 1, BIG);
    drain(400);
    chk("d1_down_freq", int'(fo[1]), 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
